ntt_intt_ctrl_regs: RTL and testbench

Control/status register block for the NTT/INTT accelerator, sitting directly upstream of the accelerator core on the X-HEEP external peripheral port. It occupies the 0x2000-byte peripheral window at peripheral index 0 and decodes single-word register accesses. It drives start/mode to the core, tracks busy/done with a small FSM, measures operation latency and raises a level interrupt on completion.

---
 rtl/ntt_intt_ctrl_regs.sv | 215 +++++++++++++++++++++
 tb/tb_ntt_intt_ctrl_regs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_intt_ctrl_regs.sv
// ntt_intt_ctrl_regs
// -----------------------------------------------------------------------------
// Control/status register block for the NTT/INTT accelerator on the X-HEEP
// external peripheral port (0x2000-byte window, single-word accesses).
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 CTRL    bit0 START (write-1, self-clearing, reads 0), bit1 MODE (rw)
//   0x04 STATUS  bit0 BUSY (ro), bit1 DONE (sticky, write-1-to-clear)
//   0x08 IRQ_EN  bit0 (rw)
//   0x0C CYCLES  latency of the last completed operation (ro)
//   0x10..0x1FFC read 0 / write dropped, both with rsp_error_o=1
//
// Optional feature macro: NTT_INTT_CYCLE_CNT_EN
//   defined     : 32-bit saturating latency counter and CYCLES register exist.
//   not defined : no counter logic; CYCLES reads 0 without error.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake (ready tied high)
//   req_write_i, req_addr_i,  request type, byte address,
//   req_be_i, req_wdata_i     byte enables, write data
//   rsp_valid_o, rsp_rdata_o, response one cycle after each request
//   rsp_error_o
//   core_start_o, core_mode_o start pulse and NTT(0)/INTT(1) mode to the core
//   core_done_i               completion pulse from the core
//   irq_o                     level interrupt, DONE & IRQ_EN (registered)
// -----------------------------------------------------------------------------
module ntt_intt_ctrl_regs #(
  parameter int unsigned           ADDR_WIDTH = 32,
  // X-HEEP EXT_PERIPHERAL_START_ADDRESS, peripheral index 0.
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h3000_0000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3:0]            req_be_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  core_start_o,
  output logic                  core_mode_o,
  input  logic                  core_done_i,
  output logic                  irq_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [10:0] IDX_CTRL   = 11'd0;
  localparam logic [10:0] IDX_STATUS = 11'd1;
  localparam logic [10:0] IDX_IRQ_EN = 11'd2;
  localparam logic [10:0] IDX_CYCLES = 11'd3;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        irq_en_q, irq_en_d;
  logic        start_q, start_d;
  logic        irq_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  // Word index inside the window: offset bits [12:2].
  logic [10:0] word_idx;
  logic        sel_ctrl, sel_status, sel_irq_en, sel_bad;
  logic        rd_req, wr_en, start_req, launch, finish;
  logic [31:0] cycles_rd;

  assign word_idx   = 11'((req_addr_i - BASE_ADDR) >> 2);
  assign sel_ctrl   = (word_idx == IDX_CTRL);
  assign sel_status = (word_idx == IDX_STATUS);
  assign sel_irq_en = (word_idx == IDX_IRQ_EN);
  assign sel_bad    = (word_idx > IDX_CYCLES);

  assign rd_req    = req_valid_i & ~req_write_i;
  // All writable fields live in byte 0, so only req_be_i[0] gates a write.
  assign wr_en     = req_valid_i & req_write_i & req_be_i[0] & ~sel_bad;
  assign start_req = wr_en & sel_ctrl & req_wdata_i[0];
  assign launch    = (state_q == ST_IDLE) & start_req;
  assign finish    = (state_q == ST_RUN) & core_done_i;

  // Upper byte enables and write data bits carry no fields.
  logic unused_bits;
  assign unused_bits = ^{req_be_i[3:1], req_wdata_i[31:2]};

`ifdef NTT_INTT_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cycles_q, cycles_d;

  // The counter is seeded with 1 at launch, so it already reads 1 in the
  // core_start_o cycle and equals the inclusive start-to-done latency when
  // core_done_i arrives.
  always_comb begin
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    if (launch) begin
      cnt_d = 32'd1;
    end else if (finish) begin
      cycles_d = cnt_q;
    end else if (state_q == ST_RUN && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    start_d  = 1'b0;

    if (wr_en && sel_irq_en) begin
      irq_en_d = req_wdata_i[0];
    end
    // Clear first so a same-cycle completion below overrides it (set wins).
    if (wr_en && sel_status && req_wdata_i[1]) begin
      done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_en && sel_ctrl) begin
          mode_d = req_wdata_i[1];
        end
        if (launch) begin
          state_d = ST_RUN;
          start_d = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // MODE and START writes are ignored while the core is busy.
        if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response path: data and error are captured from the request cycle.
  always_comb begin
    rsp_rdata_d = '0;
    rsp_error_d = req_valid_i & (sel_bad | ((state_q == ST_RUN) & start_req));
    if (rd_req) begin
      case (word_idx)
        IDX_CTRL:   rsp_rdata_d = {30'd0, mode_q, 1'b0};
        IDX_STATUS: rsp_rdata_d = {30'd0, done_q, state_q == ST_RUN};
        IDX_IRQ_EN: rsp_rdata_d = {31'd0, irq_en_q};
        IDX_CYCLES: rsp_rdata_d = cycles_rd;
        default:    rsp_rdata_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      start_q     <= start_d;
      irq_q       <= done_q & irq_en_q;
      rsp_valid_q <= req_valid_i;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready_o  = 1'b1;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_error_o  = rsp_error_q;
  assign core_start_o = start_q;
  assign core_mode_o  = mode_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_ntt_intt_ctrl_regs.sv
// tb_ntt_intt_ctrl_regs
// -----------------------------------------------------------------------------
// Directed self-checking bench for ntt_intt_ctrl_regs. Each bus access takes
// one clock; the response is sampled 1 time unit after the accepting edge.
// Expected CYCLES depends on NTT_INTT_CYCLE_CNT_EN.
// -----------------------------------------------------------------------------
module tb_ntt_intt_ctrl_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        core_start;
  logic        core_mode;
  logic        core_done = 1'b0;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef NTT_INTT_CYCLE_CNT_EN
  localparam logic [31:0] EXP_CYCLES = 32'd11;
`else
  localparam logic [31:0] EXP_CYCLES = 32'd0;
`endif

  always #5 clk = ~clk;

  ntt_intt_ctrl_regs #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_be_i     (req_be),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .core_start_o (core_start),
    .core_mode_o  (core_mode),
    .core_done_i  (core_done),
    .irq_o        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus request, accepted at the next rising edge.
  task automatic access(input string tag, input logic wr, input logic [31:0] off,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = BASE + off;
    req_be    = be;
    req_wdata = wdata;
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_be    = '0;
    req_wdata = '0;
    check({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
    rdata = rsp_rdata;
    err   = rsp_error;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic        e;
    access(tag, 1'b0, off, 4'hF, 32'd0, d, e);
    check({tag, ".rdata"}, d, exp_d);
    check({tag, ".err"}, {31'd0, e}, {31'd0, exp_e});
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] off, input logic [3:0] be,
                        input logic [31:0] wdata, input logic exp_e);
    logic [31:0] d;
    logic        e;
    access(tag, 1'b1, off, be, wdata, d, e);
    check({tag, ".rdata"}, d, 32'd0);
    check({tag, ".err"}, {31'd0, e}, {31'd0, exp_e});
  endtask

  // Launch an operation and return core_done_i n cycles after the start pulse.
  task automatic run_op(input string tag, input logic mode, input int n);
    wr_chk({tag, ".start"}, 32'h0, 4'hF, {30'd0, mode, 1'b1}, 1'b0);
    check({tag, ".pulse"}, {31'd0, core_start}, 32'd1);
    check({tag, ".mode"}, {31'd0, core_mode}, {31'd0, mode});
    tick(n);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- reset state ----
    #12;
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.start", {31'd0, core_start}, 32'd0);
    check("rst.mode", {31'd0, core_mode}, 32'd0);
    check("rst.irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_chk("rst.ctrl", 32'h00, 32'd0, 1'b0);
    rd_chk("rst.status", 32'h04, 32'd0, 1'b0);
    rd_chk("rst.irq_en", 32'h08, 32'd0, 1'b0);
    rd_chk("rst.cycles", 32'h0C, 32'd0, 1'b0);
    tick(1);
    check("idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle.irq", {31'd0, irq}, 32'd0);

    // ---- START with byte 0 disabled has no effect ----
    wr_chk("be0off", 32'h00, 4'hE, 32'h3, 1'b0);
    check("be0off.pulse", {31'd0, core_start}, 32'd0);
    rd_chk("be0off.status", 32'h04, 32'd0, 1'b0);

    // ---- basic INTT op, done 10 cycles after the pulse ----
    wr_chk("op1.start", 32'h00, 4'hF, 32'h3, 1'b0);
    check("op1.pulse", {31'd0, core_start}, 32'd1);
    check("op1.mode", {31'd0, core_mode}, 32'd1);
    rd_chk("op1.busy", 32'h04, 32'h1, 1'b0);
    check("op1.pulse_end", {31'd0, core_start}, 32'd0);
    tick(9);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    rd_chk("op1.status", 32'h04, 32'h2, 1'b0);
    rd_chk("op1.cycles", 32'h0C, EXP_CYCLES, 1'b0);
    rd_chk("op1.ctrl", 32'h00, 32'h2, 1'b0);

    // ---- interrupt rise and fall ----
    wr_chk("irq.en", 32'h08, 4'hF, 32'h1, 1'b0);
    rd_chk("irq.en_rd", 32'h08, 32'h1, 1'b0);
    run_op("irq.op", 1'b0, 3);
    check("irq.before", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq.rise", {31'd0, irq}, 32'd1);
    wr_chk("irq.clr", 32'h04, 4'hF, 32'h2, 1'b0);
    check("irq.hold", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq.fall", {31'd0, irq}, 32'd0);
    rd_chk("irq.status", 32'h04, 32'h0, 1'b0);

    // ---- writes while busy, out-of-range offsets ----
    wr_chk("busy.start", 32'h00, 4'hF, 32'h3, 1'b0);
    wr_chk("busy.restart", 32'h00, 4'hF, 32'h1, 1'b1);
    check("busy.no_pulse", {31'd0, core_start}, 32'd0);
    check("busy.mode1", {31'd0, core_mode}, 32'd1);
    wr_chk("busy.modewr", 32'h00, 4'hF, 32'h0, 1'b0);
    check("busy.mode2", {31'd0, core_mode}, 32'd1);
    rd_chk("busy.bad_rd", 32'h1000, 32'd0, 1'b1);
    wr_chk("busy.bad_wr", 32'h1FFC, 4'hF, 32'hFFFF_FFFF, 1'b1);
    rd_chk("busy.status", 32'h04, 32'h1, 1'b0);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    rd_chk("busy.done", 32'h04, 32'h2, 1'b0);

    // ---- DONE clear races core_done_i: set wins ----
    wr_chk("race.start", 32'h00, 4'hF, 32'h1, 1'b0);
    rd_chk("race.cleared", 32'h04, 32'h1, 1'b0);
    tick(2);
    core_done = 1'b1;
    wr_chk("race.w1c", 32'h04, 4'hF, 32'h2, 1'b0);
    core_done = 1'b0;
    rd_chk("race.status", 32'h04, 32'h2, 1'b0);

    // ---- core_done_i in IDLE is ignored ----
    wr_chk("idle.clr", 32'h04, 4'hF, 32'h2, 1'b0);
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    rd_chk("idle.done_ign", 32'h04, 32'h0, 1'b0);

    // ---- asynchronous reset during the start-pulse cycle ----
    wr_chk("arst.start", 32'h00, 4'hF, 32'h3, 1'b0);
    check("arst.pre_pulse", {31'd0, core_start}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst.rsp_err", {31'd0, rsp_error}, 32'd0);
    check("arst.rdata", rsp_rdata, 32'd0);
    check("arst.start", {31'd0, core_start}, 32'd0);
    check("arst.mode", {31'd0, core_mode}, 32'd0);
    check("arst.irq", {31'd0, irq}, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd_chk("arst.status", 32'h04, 32'd0, 1'b0);
    rd_chk("arst.ctrl", 32'h00, 32'd0, 1'b0);
    rd_chk("arst.irq_en", 32'h08, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
